pipe_ex_mem_hs: RTL

PIPE_EX_MEM_HS -- requirements
Module: pipe_ex_mem_hs

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_slot.sv | 27 ++
 rtl/pipe_ex_mem_hs.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline definitions: default widths and the packed EX/MEM entry.
package pipe_pkg;
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_REG_AW = 5;

  typedef struct packed {
    logic [PIPE_DATA_W-1:0] alu_result;
    logic [PIPE_DATA_W-1:0] store_data;
    logic                   write;
    logic                   mem_read;
    logic                   mem_write;
    logic [PIPE_REG_AW-1:0] write_register;
  } ex_mem_t;
endpackage

// File: rtl/pipe_slot.sv
// One entry register with valid bit; contents are zeroed whenever the slot empties.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter type entry_t = ex_mem_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   drop,
  input  entry_t d,
  output entry_t q,
  output logic   valid
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (drop) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end
endmodule

// File: rtl/pipe_ex_mem_hs.sv
// EX/MEM register stage with valid/ready handshake and a skid slot (registered in_ready).
// Optional PIPE_PERF_EN adds a saturating output-stall counter (stall_cnt).
module pipe_ex_mem_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic              write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [REG_AW-1:0] write_register_i,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic              write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [REG_AW-1:0] write_register_o
`ifdef PIPE_PERF_EN
  ,output logic [31:0]      stall_cnt
`endif
);
  // Same layout as pipe_pkg::ex_mem_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic              write;
    logic              mem_read;
    logic              mem_write;
    logic [REG_AW-1:0] write_register;
  } entry_t;

  entry_t in_ent, main_d, main_q, skid_q;
  logic   main_v, skid_v;
  logic   in_fire, out_fire;
  logic   main_load, main_drop, skid_load, skid_drop;

  always_comb begin
    in_ent                = '0;
    in_ent.alu_result     = alu_result_i;
    in_ent.store_data     = store_data_i;
    in_ent.write          = write_i && (write_register_i != '0);
    in_ent.mem_read       = mem_read_i;
    in_ent.mem_write      = mem_write_i;
    in_ent.write_register = write_register_i;
  end

  // skid_v is a flop, so in_ready never depends on out_ready combinationally.
  assign in_ready = ~skid_v;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_v & out_ready;

  always_comb begin
    main_load = 1'b0;
    main_drop = 1'b0;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    main_d    = skid_v ? skid_q : in_ent;
    if (flush) begin
      main_drop = 1'b1;
      skid_drop = 1'b1;
    end else begin
      if (!main_v || out_fire) begin
        if (skid_v || in_fire) main_load = 1'b1;
        else if (out_fire)     main_drop = 1'b1;
      end
      if (skid_v && out_fire)                   skid_drop = 1'b1;
      else if (in_fire && main_v && !out_fire)  skid_load = 1'b1;
    end
  end

  pipe_slot #(.entry_t(entry_t)) u_main (
    .clk(clk), .reset(reset), .load(main_load), .drop(main_drop),
    .d(main_d), .q(main_q), .valid(main_v)
  );

  pipe_slot #(.entry_t(entry_t)) u_skid (
    .clk(clk), .reset(reset), .load(skid_load), .drop(skid_drop),
    .d(in_ent), .q(skid_q), .valid(skid_v)
  );

  assign out_valid        = main_v;
  assign alu_result_o     = main_q.alu_result;
  assign store_data_o     = main_q.store_data;
  assign write_o          = main_q.write;
  assign mem_read_o       = main_q.mem_read;
  assign mem_write_o      = main_q.mem_write;
  assign write_register_o = main_q.write_register;

`ifdef PIPE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                       stall_cnt <= '0;
    else if (main_v && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule
